// File: rtl/gpio_in_conditioner_pkg.sv
// Shared constants and helpers for the GPIO input conditioner.
package gpio_pkg;

    localparam int unsigned C_GPIO_WIDTH  = 32;
    localparam int unsigned C_GPIO2_WIDTH = 32;
    localparam int unsigned DB_CYCLES_DEF = 4;

    // Per-cycle action taken by one debounce channel.
    typedef enum logic [1:0] {
        DB_HOLD   = 2'd0,
        DB_COUNT  = 2'd1,
        DB_ACCEPT = 2'd2
    } db_act_e;

    function automatic int unsigned cnt_width(input int unsigned db_cycles);
        return $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO input channel: 2-flop synchronizer followed by a stable-count debouncer.
module gpio_debounce_bit #(
    parameter int unsigned DB_CYCLES = gpio_pkg::DB_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_stable,
    output logic o_chg
);
    import gpio_pkg::*;

    localparam int unsigned   CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    db_act_e       w_act;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
        end
    end

    always_comb begin
        w_act = DB_HOLD;
        if (r_sync != r_stable) begin
            w_act = (r_cnt == CNT_LAST) ? DB_ACCEPT : DB_COUNT;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (w_act)
                DB_COUNT: r_cnt <= r_cnt + 1'b1;
                DB_ACCEPT: begin
                    r_stable <= r_sync;
                    r_cnt    <= '0;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Change event is combinational so status can set on the same edge as the level.
    assign o_stable = r_stable;
    assign o_chg    = (w_act == DB_ACCEPT);

endmodule

// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: per-bit synchronise + debounce, optional change interrupt.
// Define GPIO_IN_IRQ_EN to build the sticky status register and interrupt output.
module gpio_in_conditioner #(
    parameter int unsigned C_GPIO_WIDTH = gpio_pkg::C_GPIO_WIDTH,
    parameter int unsigned DB_CYCLES    = gpio_pkg::DB_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    s_axi_aresetn,
    input  logic [C_GPIO_WIDTH-1:0] pin_i,
    input  logic [C_GPIO_WIDTH-1:0] gpio_io_t,
    output logic [C_GPIO_WIDTH-1:0] gpio_io_i,
    input  logic [C_GPIO_WIDTH-1:0] irq_mask,
    input  logic [C_GPIO_WIDTH-1:0] irq_clr,
    output logic [C_GPIO_WIDTH-1:0] irq_status,
    output logic                    ip2intc_irpt
);

    logic [C_GPIO_WIDTH-1:0] w_stable;
    logic [C_GPIO_WIDTH-1:0] w_chg;

    for (genvar g = 0; g < C_GPIO_WIDTH; g++) begin : g_bit
        gpio_debounce_bit #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .i_clk    (clk),
            .i_rst_n  (s_axi_aresetn),
            .i_pin    (pin_i[g]),
            .o_stable (w_stable[g]),
            .o_chg    (w_chg[g])
        );
    end

    assign gpio_io_i = w_stable;

`ifdef GPIO_IN_IRQ_EN
    logic [C_GPIO_WIDTH-1:0] r_irq_status;
    logic                    r_irpt;

    // Set term is OR'd after the clear so a coincident event keeps the flag.
    always_ff @(posedge clk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_irq_status <= '0;
            r_irpt       <= 1'b0;
        end else begin
            r_irq_status <= (r_irq_status & ~irq_clr) | (w_chg & gpio_io_t);
            r_irpt       <= |(r_irq_status & irq_mask);
        end
    end

    assign irq_status   = r_irq_status;
    assign ip2intc_irpt = r_irpt;
`else
    logic w_unused_irq;

    assign w_unused_irq = ^{irq_mask, irq_clr, gpio_io_t, w_chg};
    assign irq_status   = '0;
    assign ip2intc_irpt = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Bench for gpio_in_conditioner: directed scenarios plus randomized pins vs a window model.
module tb_gpio_in_conditioner;

    localparam int W  = 32;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] pin;
    logic [W-1:0] tri_t;
    logic [W-1:0] mask;
    logic [W-1:0] clr;
    logic [W-1:0] gio;
    logic [W-1:0] st;
    logic         irpt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gpio_in_conditioner #(
        .C_GPIO_WIDTH(W),
        .DB_CYCLES   (DB)
    ) dut (
        .clk          (clk),
        .s_axi_aresetn(rst_n),
        .pin_i        (pin),
        .gpio_io_t    (tri_t),
        .gpio_io_i    (gio),
        .irq_mask     (mask),
        .irq_clr      (clr),
        .irq_status   (st),
        .ip2intc_irpt (irpt)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: a level is accepted once the synchronised value has
    // differed from the accepted level for DB consecutive samples.
    logic [W-1:0] pq[$];
    logic [W-1:0] sw[$];
    logic [W-1:0] m_stable;
    logic [W-1:0] m_status;
    logic         m_irpt;

    task automatic model_reset();
        pq.delete();
        pq.push_back('0);
        pq.push_back('0);
        sw.delete();
        for (int i = 0; i < DB; i++) sw.push_back('0);
        m_stable = '0;
        m_status = '0;
        m_irpt   = 1'b0;
    endtask

    task automatic model_step();
        logic [W-1:0] s, all1, any1, nst, chg;
        s = pq.pop_front();
        pq.push_back(pin);
        sw.push_back(s);
        void'(sw.pop_front());
        all1 = '1;
        any1 = '0;
        foreach (sw[i]) begin
            all1 &= sw[i];
            any1 |= sw[i];
        end
        nst = all1 | (m_stable & any1);
        chg = nst ^ m_stable;
`ifdef GPIO_IN_IRQ_EN
        m_irpt   = |(m_status & mask);
        m_status = (m_status & ~clr) | (chg & tri_t);
`else
        m_irpt   = 1'b0;
        m_status = '0;
`endif
        m_stable = nst;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_gpio"}, gio, m_stable);
        chk({tag, "_status"}, st, m_status);
        chk({tag, "_irpt"}, W'(irpt), W'(m_irpt));
    endtask

    // One clock: model advances on pre-edge inputs, outputs checked 2 time units later.
    task automatic cyc(input string tag = "cyc");
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #2;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        pin   = '0;
        tri_t = '1;
        mask  = '1;
        clr   = '0;
        model_reset();
        repeat (3) cyc("reset");
        chk("reset_gpio_zero", gio, '0);
        chk("reset_irpt_zero", W'(irpt), '0);
        rst_n = 1'b1;
        repeat (3) cyc("idle");

        // Clean step on bit 0: level and status on edge 6, interrupt on edge 7.
        pin[0] = 1'b1;
        repeat (5) cyc("step0");
        chk("step0_e5_gpio", W'(gio[0]), W'(0));
        cyc("step0");
        chk("step0_e6_gpio", W'(gio[0]), W'(1));
`ifdef GPIO_IN_IRQ_EN
        chk("step0_e6_status", W'(st[0]), W'(1));
        chk("step0_e6_irpt", W'(irpt), W'(0));
`endif
        cyc("step0");
`ifdef GPIO_IN_IRQ_EN
        chk("step0_e7_irpt", W'(irpt), W'(1));
`endif
        clr = '1;
        cyc("clr_all");
        clr = '0;

        // Glitch of 3 cycles on bit 3 is rejected.
        pin[3] = 1'b1;
        repeat (3) cyc("glitch3");
        pin[3] = 1'b0;
        repeat (8) cyc("glitch3");
        chk("glitch3_gpio", W'(gio[3]), W'(0));
        chk("glitch3_status", W'(st[3]), W'(0));

        // Set-wins-over-clear on bit 5, then a lone clear.
        mask   = W'(1) << 5;
        pin[5] = 1'b1;
        repeat (6) cyc("b5_set");
`ifdef GPIO_IN_IRQ_EN
        chk("b5_set_status", W'(st[5]), W'(1));
`endif
        pin[5] = 1'b0;
        repeat (5) cyc("b5_fall");
        clr[5] = 1'b1;
        cyc("b5_coinc");
        clr = '0;
        chk("b5_coinc_gpio", W'(gio[5]), W'(0));
`ifdef GPIO_IN_IRQ_EN
        chk("b5_coinc_status", W'(st[5]), W'(1));
`endif
        repeat (2) cyc("b5_hold");
        clr[5] = 1'b1;
        cyc("b5_clr");
        clr = '0;
        chk("b5_clr_status", W'(st[5]), W'(0));
`ifdef GPIO_IN_IRQ_EN
        chk("b5_clr_irpt_lag", W'(irpt), W'(1));
`endif
        cyc("b5_clr");
        chk("b5_clr_irpt_low", W'(irpt), W'(0));

        // Output-direction bit still debounces but never flags status.
        mask     = '1;
        tri_t[2] = 1'b0;
        pin[2]   = 1'b1;
        repeat (5) cyc("out2");
        chk("out2_e5_gpio", W'(gio[2]), W'(0));
        cyc("out2");
        chk("out2_e6_gpio", W'(gio[2]), W'(1));
        chk("out2_status", W'(st[2]), W'(0));
        pin[2] = 1'b0;
        repeat (6) cyc("out2");
        chk("out2_fall_gpio", W'(gio[2]), W'(0));
        chk("out2_fall_status", W'(st[2]), W'(0));
        tri_t = '1;

        // Reset mid-debounce on bit 7 (count at 2), release with pin still high.
        pin[7] = 1'b1;
        repeat (4) cyc("mid_rst");
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_gpio", gio, '0);
        chk("mid_rst_status", st, '0);
        chk("mid_rst_irpt", W'(irpt), '0);
        repeat (2) cyc("in_rst");
        rst_n = 1'b1;
        repeat (5) cyc("post_rst");
        chk("post_rst_e5_gpio", W'(gio[7]), W'(0));
        cyc("post_rst");
        chk("post_rst_e6_gpio", W'(gio[7]), W'(1));

        // Randomized pins, direction, mask, clears and occasional resets.
        for (int n = 0; n < 800; n++) begin
            pin ^= ($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) tri_t = $urandom;
            if ($urandom_range(0, 15) == 0) mask = $urandom;
            clr = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom) : '0;
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all("rnd_rst");
                cyc("rnd_rst");
                rst_n = 1'b1;
            end
            cyc("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
